// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch/execute sequencer that owns the program counter. PC_BOUNDS_CHECK_EN enables target bounds faulting.
// Min 2 cycles/instruction; FETCH holds until imem_ack_i, EXEC holds while stall_i is high or exec_done_i is low.
module pc_sequencer #(
    parameter int unsigned         PC_WIDTH   = 32,
    parameter logic [PC_WIDTH-1:0] RESET_ADDR = '0,
    parameter int unsigned         IMEM_DEPTH = 256
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    output logic                imem_req_o,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic                imem_ack_i,
    output logic                instr_valid_o,
    input  logic                exec_done_i,
    input  logic                jmp_i,
    input  logic                jmp_if_i,
    input  logic                alu_out_lsb_i,
    input  logic [PC_WIDTH-1:0] imm_padded_out_i,
    input  logic                stall_i,
    input  logic                halt_req_i,
    output logic [PC_WIDTH-1:0] pc_o,
    output logic                halted_o,
    output logic                fault_o
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT
`ifdef PC_BOUNDS_CHECK_EN
        , FAULT
`endif
    } state_t;

`ifdef PC_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif
    localparam logic [PC_WIDTH:0] DEPTH_W = (PC_WIDTH + 1)'(IMEM_DEPTH);

    state_t              state_q;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic                imem_req_q;
    logic                instr_valid_q;
    logic                halted_q;
    logic                taken;
    logic                pc_oob;
`ifdef PC_BOUNDS_CHECK_EN
    logic                fault_q;
`endif

    // Next-PC candidate, only committed on an unstalled exec_done_i in EXEC.
    always_comb begin
        taken  = jmp_i | (jmp_if_i & alu_out_lsb_i);
        pc_d   = taken ? imm_padded_out_i : pc_q + PC_WIDTH'(1);
        pc_oob = BOUNDS_EN && ({1'b0, pc_d} >= DEPTH_W);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q       <= IDLE;
            pc_q          <= RESET_ADDR;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
            fault_q       <= 1'b0;
`endif
        end else begin
            instr_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (halt_req_i) begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end else begin
                        state_q    <= FETCH;
                        imem_req_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (imem_ack_i) begin
                        state_q       <= EXEC;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_done_i && !stall_i) begin
                        if (pc_oob) begin
`ifdef PC_BOUNDS_CHECK_EN
                            state_q <= FAULT;
                            fault_q <= 1'b1;
`endif
                        end else begin
                            pc_q <= pc_d;
                            if (halt_req_i) begin
                                state_q  <= HALT;
                                halted_q <= 1'b1;
                            end else begin
                                state_q    <= FETCH;
                                imem_req_q <= 1'b1;
                            end
                        end
                    end
                end
                HALT: begin
                    if (!halt_req_i) begin
                        state_q    <= FETCH;
                        imem_req_q <= 1'b1;
                        halted_q   <= 1'b0;
                    end
                end
`ifdef PC_BOUNDS_CHECK_EN
                FAULT: begin
                    state_q <= FAULT;
                end
`endif
                default: begin
                    state_q    <= IDLE;
                    imem_req_q <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = imem_req_q;
    assign imem_addr_o   = pc_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = instr_valid_q;
    assign halted_o      = halted_q;
`ifdef PC_BOUNDS_CHECK_EN
    assign fault_o       = fault_q;
`else
    assign fault_o       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scenario bench for pc_sequencer: expected fetch addresses queued at drive time, compared when the fetch appears.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic        instr_valid;
    logic        exec_done;
    logic        jmp;
    logic        jmp_if;
    logic        alu_lsb;
    logic [31:0] imm;
    logic        stall;
    logic        halt_req;
    logic [31:0] pc;
    logic        halted;
    logic        fault;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_pc;

    always #5 clk = ~clk;

    pc_sequencer #(
        .PC_WIDTH  (32),
        .RESET_ADDR(32'h0),
        .IMEM_DEPTH(256)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_ack_i      (imem_ack),
        .instr_valid_o   (instr_valid),
        .exec_done_i     (exec_done),
        .jmp_i           (jmp),
        .jmp_if_i        (jmp_if),
        .alu_out_lsb_i   (alu_lsb),
        .imm_padded_out_i(imm),
        .stall_i         (stall),
        .halt_req_i      (halt_req),
        .pc_o            (pc),
        .halted_o        (halted),
        .fault_o         (fault)
    );

    task automatic clear_inputs();
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        jmp       = 1'b0;
        jmp_if    = 1'b0;
        alu_lsb   = 1'b0;
        imm       = 32'h0;
        stall     = 1'b0;
        halt_req  = 1'b0;
    endtask

    // Returns at the negedge of the first FETCH cycle after reset release.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_pc = 32'h0;
        exp_q.delete();
        @(negedge clk);
    endtask

    // Acks the pending fetch, then completes the instruction; queues the expected next fetch address.
    task automatic fetch_exec(input bit j, input bit ji, input bit lsb, input logic [31:0] target,
                              output bit vld_seen);
        logic [31:0] nxt;
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack  = 1'b0;
        vld_seen  = instr_valid;
        jmp       = j;
        jmp_if    = ji;
        alu_lsb   = lsb;
        imm       = target;
        exec_done = 1'b1;
        nxt = (j | (ji & lsb)) ? target : model_pc + 32'd1;
        model_pc = nxt;
        exp_q.push_back(nxt);
        @(negedge clk);
        exec_done = 1'b0;
        jmp       = 1'b0;
        jmp_if    = 1'b0;
        alu_lsb   = 1'b0;
        imm       = 32'h0;
    endtask

    task automatic test_reset();
        clear_inputs();
        imem_ack  = 1'b1;
        exec_done = 1'b1;
        rst_n     = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b want 0", fault); end
        clear_inputs();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL first_req got req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        do_reset();
        for (int k = 0; k < 4; k++) exp_q.push_back(32'(k));
        imem_ack  = 1'b1;
        exec_done = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp = exp_q.pop_front();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp) begin
                errors++; $display("FAIL seq_fetch%0d got req=%b addr=%h want 1/%h", k, imem_req, imem_addr, exp);
            end
            @(negedge clk);
            checks++;
            if (instr_valid !== 1'b1 || imem_req !== 1'b0) begin
                errors++; $display("FAIL seq_exec%0d got valid=%b req=%b want 1/0", k, instr_valid, imem_req);
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_jumps();
        bit          tj[10]   = '{0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
        bit          tji[10]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        bit          tlsb[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
        logic [31:0] timm[10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                                  32'h40, 32'h99, 32'h10, 32'h77, 32'h55};
        logic [31:0] exp;
        bit          v;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            fetch_exec(tj[i], tji[i], tlsb[i], timm[i], v);
            checks++;
            if (v !== 1'b1) begin errors++; $display("FAIL jump_valid%0d got %b want 1", i, v); end
            exp = exp_q.pop_front();
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== exp) begin
                errors++; $display("FAIL jump_fetch%0d got req=%b addr=%h want 1/%h", i, imem_req, imem_addr, exp);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp;
        int          pulses;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
                errors++; $display("FAIL ack_wait%0d got req=%b addr=%h want 1/0", i, imem_req, imem_addr);
            end
        end
        imem_ack  = 1'b1;
        stall     = 1'b1;
        exec_done = 1'b1;
        exp_q.push_back(32'h1);
        @(negedge clk);
        imem_ack = 1'b0;
        pulses   = (instr_valid === 1'b1) ? 1 : 0;
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL stall_entry_pc got %h want 0", pc); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (instr_valid === 1'b1) pulses++;
            checks++;
            if (pc !== 32'h0 || imem_req !== 1'b0) begin
                errors++; $display("FAIL stall_hold%0d got pc=%h req=%b want 0/0", i, pc, imem_req);
            end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL stall_pulses got %0d want 1", pulses); end
        stall = 1'b0;
        @(negedge clk);
        exec_done = 1'b0;
        exp = exp_q.pop_front();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp) begin
            errors++; $display("FAIL stall_release got req=%b addr=%h want 1/%h", imem_req, imem_addr, exp);
        end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_valid_after got %b want 0", instr_valid); end
        model_pc = 32'h1;
    endtask

`ifndef PC_BOUNDS_CHECK_EN
    task automatic test_wrap();
        logic [31:0] exp;
        bit          v;
        do_reset();
        fetch_exec(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, v);
        exp = exp_q.pop_front();
        checks++;
        if (imem_addr !== exp) begin errors++; $display("FAIL wrap_top got %h want %h", imem_addr, exp); end
        fetch_exec(1'b0, 1'b0, 1'b0, 32'h0, v);
        exp = exp_q.pop_front();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp) begin
            errors++; $display("FAIL wrap_zero got req=%b addr=%h want 1/%h", imem_req, imem_addr, exp);
        end
        checks++; if (fault !== 1'b0) begin errors++; $display("FAIL wrap_fault got %b want 0", fault); end
    endtask
`endif

    task automatic test_halt();
        logic [31:0] exp;
        bit          v;
        do_reset();
        halt_req = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || halted !== 1'b0 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL halt_in_fetch got req=%b halted=%b addr=%h want 1/0/0", imem_req, halted, imem_addr);
        end
        fetch_exec(1'b0, 1'b0, 1'b0, 32'h0, v);
        exp = exp_q.pop_front();
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL halt_valid got %b want 1", v); end
        checks++;
        if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== exp) begin
            errors++; $display("FAIL halt_enter got halted=%b req=%b pc=%h want 1/0/%h", halted, imem_req, pc, exp);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (halted !== 1'b1 || pc !== exp) begin
            errors++; $display("FAIL halt_hold got halted=%b pc=%h want 1/%h", halted, pc, exp);
        end
        halt_req = 1'b0;
        @(negedge clk);
        checks++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== exp) begin
            errors++; $display("FAIL halt_resume got halted=%b req=%b addr=%h want 0/1/%h", halted, imem_req, imem_addr, exp);
        end
    endtask

    task automatic test_reset_mid_fetch();
        logic [31:0] exp;
        bit          v;
        do_reset();
        fetch_exec(1'b1, 1'b0, 1'b0, 32'h33, v);
        exp = exp_q.pop_front();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== exp) begin
            errors++; $display("FAIL midrst_pre got req=%b addr=%h want 1/%h", imem_req, imem_addr, exp);
        end
        rst_n    = 1'b0;
        imem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (pc !== 32'h0 || imem_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++; $display("FAIL midrst got pc=%h req=%b valid=%b want 0/0/0", pc, imem_req, instr_valid);
        end
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
            errors++; $display("FAIL midrst_restart got req=%b addr=%h want 1/0", imem_req, imem_addr);
        end
    endtask

`ifdef PC_BOUNDS_CHECK_EN
    task automatic test_bounds();
        logic [31:0] exp;
        bit          v;
        do_reset();
        fetch_exec(1'b1, 1'b0, 1'b0, 32'hFF, v);
        exp = exp_q.pop_front();
        checks++;
        if (imem_addr !== exp || fault !== 1'b0) begin
            errors++; $display("FAIL bounds_last got addr=%h fault=%b want %h/0", imem_addr, fault, exp);
        end
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack  = 1'b0;
        jmp       = 1'b1;
        imm       = 32'h100;
        exec_done = 1'b1;
        @(negedge clk);
        clear_inputs();
        checks++;
        if (fault !== 1'b1 || imem_req !== 1'b0 || pc !== 32'hFF) begin
            errors++; $display("FAIL bounds_fault got fault=%b req=%b pc=%h want 1/0/ff", fault, imem_req, pc);
        end
        halt_req = 1'b1;
        repeat (3) @(negedge clk);
        halt_req = 1'b0;
        @(negedge clk);
        checks++;
        if (fault !== 1'b1 || halted !== 1'b0 || imem_req !== 1'b0 || pc !== 32'hFF) begin
            errors++; $display("FAIL bounds_sticky got fault=%b halted=%b req=%b pc=%h want 1/0/0/ff", fault, halted, imem_req, pc);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (fault !== 1'b0 || pc !== 32'h0) begin
            errors++; $display("FAIL bounds_clear got fault=%b pc=%h want 0/0", fault, pc);
        end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        model_pc = 32'h0;
        test_reset();
        test_sequential();
        test_jumps();
        test_stall();
`ifndef PC_BOUNDS_CHECK_EN
        test_wrap();
`endif
        test_halt();
        test_reset_mid_fetch();
`ifdef PC_BOUNDS_CHECK_EN
        test_bounds();
`endif
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
